// File: rtl/dmem_responder_pkg.sv
// dbus_pkg: shared constants for the data-bus responder.
//   MMIO_PAGE            upper address half that selects the MMIO window
//   *_OFS                word offsets of the MMIO registers within the window
//   STAT_*               bit positions inside the TXSTAT read word
//   region_e             RAM / MMIO decode result
//   decode_region()      classifies a byte address into a region_e
package dbus_pkg;

  localparam logic [15:0] MMIO_PAGE  = 16'hFFFF;

  localparam logic [15:0] LED_OFS    = 16'h0000;
  localparam logic [15:0] TXDATA_OFS = 16'h0004;
  localparam logic [15:0] TXSTAT_OFS = 16'h0008;
  localparam logic [15:0] CYCLE_OFS  = 16'h000C;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic {
    REG_RAM  = 1'b0,
    REG_MMIO = 1'b1
  } region_e;

  function automatic region_e decode_region(input logic [31:0] adr);
    return (adr[31:16] == MMIO_PAGE) ? REG_MMIO : REG_RAM;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: data-port bus between the core and the responder, plus
// the byte-stream handshake toward the TX sink.
//   MemWrite/DataAdr/WriteData  core -> responder store strobe, address, data
//   ReadData                    responder -> core load data (combinational)
//   tx_valid/tx_data            responder -> sink queue head
//   tx_ready                    sink -> responder accept
// Modports: master = core/sink side, slave = responder side.
interface dmem_responder_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output MemWrite, DataAdr, WriteData, tx_ready,
    input  ReadData, tx_valid, tx_data
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData, tx_ready,
    output ReadData, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_responder_tx_fifo.sv
// tx_fifo: synchronous FIFO with asynchronous active-high reset.
//   clk, reset   clock and async reset (reset empties the queue)
//   push, din    write request and data; accepted when not full or when a
//                pop happens in the same cycle
//   pop          read request; ignored when empty
//   dout         head entry, forced to 0 while empty
//   full, empty  status flags
//   count        number of stored entries (log2(DEPTH)+1 bits)
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem[rd_ptr];

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  // Storage is not reset; dout is masked while empty instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data port.
// Serves loads/stores from a word RAM and an MMIO window at 0xFFFF_xxxx:
//   0x0000 LED (RW), 0x0004 TXDATA (W), 0x0008 TXSTAT (R, write clears
//   overflow), 0x000C CYCLE (R).
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   bus    dmem_responder_if.slave (core data bus + TX byte stream)
//   led    LED register contents
// Build option: define DMEM_CYCLE_COUNTER_EN to include the 32-bit cycle
// counter behind CYCLE; otherwise CYCLE reads 0 and no counter exists.
module dmem_responder
  import dbus_pkg::*;
#(
  parameter int RAM_WORDS = 64,
  parameter int TXQ_DEPTH = 4,
  parameter int LED_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_responder_if.slave      bus,
  output logic [LED_W-1:0]     led
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(TXQ_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  region_e       region;
  logic [15:0]   ofs;
  logic          mmio_wr;
  logic          ram_wr;
  logic          txq_push;
  logic          txq_pop;
  logic          txq_full;
  logic          txq_empty;
  logic [CW-1:0] txq_count;
  logic [7:0]    txq_head;
  logic [LED_W-1:0] led_q;
  logic          overflow_q;
  logic [31:0]   cycle_val;
  logic [31:0]   rdata;
  logic          unused_adr_bits;

  // Byte-lane bits never matter: all accesses are whole words.
  assign unused_adr_bits = ^bus.DataAdr[1:0];

  assign region   = decode_region(bus.DataAdr);
  assign ofs      = {bus.DataAdr[15:2], 2'b00};
  assign ram_idx  = bus.DataAdr[AW+1:2];
  assign mmio_wr  = bus.MemWrite && (region == REG_MMIO);
  assign ram_wr   = bus.MemWrite && (region == REG_RAM);
  assign txq_push = mmio_wr && (ofs == TXDATA_OFS);
  assign txq_pop  = bus.tx_valid && bus.tx_ready;

  // RAM write port; reads are combinational so a same-cycle read sees old data.
  always_ff @(posedge clk) begin
    if (ram_wr) ram[ram_idx] <= bus.WriteData;
  end

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (TXQ_DEPTH)
  ) u_txq (
    .clk   (clk),
    .reset (reset),
    .push  (txq_push),
    .din   (bus.WriteData[7:0]),
    .pop   (txq_pop),
    .dout  (txq_head),
    .full  (txq_full),
    .empty (txq_empty),
    .count (txq_count)
  );

  assign bus.tx_valid = !txq_empty;
  assign bus.tx_data  = txq_head;

  // LED register and sticky overflow flag. A dropped push is one that finds
  // the queue full with no pop freeing a slot in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (mmio_wr && ofs == LED_OFS) led_q <= bus.WriteData[LED_W-1:0];
      if (mmio_wr && ofs == TXSTAT_OFS)             overflow_q <= 1'b0;
      else if (txq_push && txq_full && !txq_pop)    overflow_q <= 1'b1;
    end
  end

  assign led = led_q;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_q;

  // Free-running; CYCLE reads the value before this edge's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cycle_q <= '0;
    else       cycle_q <= cycle_q + 32'd1;
  end

  assign cycle_val = cycle_q;
`else
  assign cycle_val = '0;
`endif

  // Load data mux.
  always_comb begin
    rdata = '0;
    if (region == REG_RAM) begin
      rdata = ram[ram_idx];
    end else begin
      case (ofs)
        LED_OFS:    rdata[LED_W-1:0] = led_q;
        TXSTAT_OFS: begin
          rdata[STAT_FULL_BIT]               = txq_full;
          rdata[STAT_EMPTY_BIT]              = txq_empty;
          rdata[STAT_OVF_BIT]                = overflow_q;
          rdata[STAT_COUNT_LSB +: CW]        = txq_count;
        end
        CYCLE_OFS:  rdata = cycle_val;
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
// (default parameters). Exercises RAM access and wrap, MMIO isolation,
// LED register and reset, TX queue overflow/drain, full push+pop, and the
// CYCLE register in whichever build DMEM_CYCLE_COUNTER_EN selects.
module tb_dmem_responder;

  logic clk;
  logic reset;
  logic [7:0] led;
  int tests_run;
  int tests_failed;

  dmem_responder_if bus_if ();

  dmem_responder #(
    .RAM_WORDS (64),
    .TXQ_DEPTH (4),
    .LED_W     (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single store: held across exactly one rising edge.
  task automatic bus_write(input logic [31:0] adr, input logic [31:0] data);
    @(negedge clk);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = adr;
    bus_if.WriteData = data;
    @(negedge clk);
    bus_if.MemWrite  = 1'b0;
  endtask

  // Combinational load sampled mid-low-phase.
  task automatic bus_read(input logic [31:0] adr, output logic [31:0] data);
    bus_if.DataAdr = adr;
    #1;
    data = bus_if.ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    bus_if.MemWrite = 1'b0;
    bus_if.DataAdr = '0;
    bus_if.WriteData = '0;
    bus_if.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (led !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_led got %h want 00", led);
    end
    tests_run++;
    if (bus_if.tx_valid !== 1'b0 || bus_if.tx_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_tx got valid=%b data=%h want 0/00", bus_if.tx_valid, bus_if.tx_data);
    end
    reset = 1'b0;
    bus_read(32'hFFFF_0008, r);
    tests_run++;
    if (r !== 32'h0000_0002) begin
      tests_failed++;
      $display("[TB] FAIL reset_txstat got %h want 00000002", r);
    end
  endtask

  task automatic test_ram();
    logic [31:0] r;
    bus_write(32'h0000_0010, 32'hDEAD_BEEF);
    bus_read(32'h0000_0010, r);
    tests_run++;
    if (r !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL ram_load got %h want deadbeef", r);
    end
    bus_read(32'h0000_0013, r);
    tests_run++;
    if (r !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL ram_load_unaligned got %h want deadbeef", r);
    end
    // Read during write returns the previous word.
    bus_write(32'h0000_0020, 32'h0000_AAAA);
    @(negedge clk);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = 32'h0000_0020;
    bus_if.WriteData = 32'h0000_BBBB;
    #1;
    r = bus_if.ReadData;
    tests_run++;
    if (r !== 32'h0000_AAAA) begin
      tests_failed++;
      $display("[TB] FAIL ram_rdw got %h want 0000aaaa", r);
    end
    @(negedge clk);
    bus_if.MemWrite = 1'b0;
    bus_read(32'h0000_0020, r);
    tests_run++;
    if (r !== 32'h0000_BBBB) begin
      tests_failed++;
      $display("[TB] FAIL ram_rdw_after got %h want 0000bbbb", r);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] r;
    bus_write(32'h0000_0000, 32'h0000_0011);
    bus_read(32'h0000_0100, r);
    tests_run++;
    if (r !== 32'h0000_0011) begin
      tests_failed++;
      $display("[TB] FAIL ram_wrap got %h want 00000011", r);
    end
    // MMIO stores whose low bits alias RAM words must not touch RAM.
    bus_write(32'hFFFF_0010, 32'h0000_0022);
    bus_write(32'hFFFF_0000, 32'h0000_0033);
    bus_read(32'h0000_0010, r);
    tests_run++;
    if (r !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("[TB] FAIL mmio_no_ram_10 got %h want deadbeef", r);
    end
    bus_read(32'h0000_0000, r);
    tests_run++;
    if (r !== 32'h0000_0011) begin
      tests_failed++;
      $display("[TB] FAIL mmio_no_ram_00 got %h want 00000011", r);
    end
    bus_read(32'hFFFF_0010, r);
    tests_run++;
    if (r !== 32'h0000_0000) begin
      tests_failed++;
      $display("[TB] FAIL mmio_unmapped got %h want 00000000", r);
    end
  endtask

  task automatic test_led();
    logic [31:0] r;
    bus_write(32'hFFFF_0000, 32'h0000_01A5);
    tests_run++;
    if (led !== 8'hA5) begin
      tests_failed++;
      $display("[TB] FAIL led_out got %h want a5", led);
    end
    bus_read(32'hFFFF_0000, r);
    tests_run++;
    if (r !== 32'h0000_00A5) begin
      tests_failed++;
      $display("[TB] FAIL led_read got %h want 000000a5", r);
    end
    // Queue two bytes, then reset between edges: LED and queue clear at once.
    bus_write(32'hFFFF_0004, 32'h0000_0077);
    bus_write(32'hFFFF_0004, 32'h0000_0078);
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (led !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL led_async_reset got %h want 00", led);
    end
    tests_run++;
    if (bus_if.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_discard got valid=%b want 0", bus_if.tx_valid);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r;
    bus_if.tx_ready = 1'b0;
    // First push into an empty queue: head not visible until after the edge.
    @(negedge clk);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = 32'hFFFF_0004;
    bus_if.WriteData = 32'h0000_0041;
    #1;
    tests_run++;
    if (bus_if.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL push_no_bypass got valid=%b want 0", bus_if.tx_valid);
    end
    @(negedge clk);
    bus_if.MemWrite = 1'b0;
    tests_run++;
    if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h41) begin
      tests_failed++;
      $display("[TB] FAIL push_latency got valid=%b data=%h want 1/41", bus_if.tx_valid, bus_if.tx_data);
    end
    for (int i = 1; i < 5; i++) bus_write(32'hFFFF_0004, 32'h0000_0041 + i);
    bus_read(32'hFFFF_0008, r);
    tests_run++;
    if (r !== 32'h0000_0405) begin
      tests_failed++;
      $display("[TB] FAIL txstat_overflow got %h want 00000405", r);
    end
    bus_write(32'hFFFF_0008, 32'h0000_0000);
    bus_read(32'hFFFF_0008, r);
    tests_run++;
    if (r !== 32'h0000_0401) begin
      tests_failed++;
      $display("[TB] FAIL txstat_clear got %h want 00000401", r);
    end
    @(negedge clk);
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== 8'h41 + 8'(i)) begin
        tests_failed++;
        $display("[TB] FAIL drain_%0d got valid=%b data=%h want 1/%h", i, bus_if.tx_valid, bus_if.tx_data, 8'h41 + 8'(i));
      end
      @(negedge clk);
    end
    bus_if.tx_ready = 1'b0;
    #1;
    tests_run++;
    if (bus_if.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drain_empty got valid=%b want 0", bus_if.tx_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [7:0] expq [4];
    expq[0] = 8'h62; expq[1] = 8'h63; expq[2] = 8'h64; expq[3] = 8'h55;
    bus_if.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(32'hFFFF_0004, 32'h0000_0061 + i);
    // Push onto the full queue while the sink takes the head.
    @(negedge clk);
    bus_if.MemWrite  = 1'b1;
    bus_if.DataAdr   = 32'hFFFF_0004;
    bus_if.WriteData = 32'h0000_0055;
    bus_if.tx_ready  = 1'b1;
    @(negedge clk);
    bus_if.MemWrite = 1'b0;
    bus_if.tx_ready = 1'b0;
    bus_read(32'hFFFF_0008, r);
    tests_run++;
    if (r !== 32'h0000_0401) begin
      tests_failed++;
      $display("[TB] FAIL full_pushpop_stat got %h want 00000401", r);
    end
    @(negedge clk);
    bus_if.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (bus_if.tx_valid !== 1'b1 || bus_if.tx_data !== expq[i]) begin
        tests_failed++;
        $display("[TB] FAIL full_pushpop_drain_%0d got valid=%b data=%h want 1/%h", i, bus_if.tx_valid, bus_if.tx_data, expq[i]);
      end
      @(negedge clk);
    end
    bus_if.tx_ready = 1'b0;
    #1;
    tests_run++;
    if (bus_if.tx_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL full_pushpop_empty got valid=%b want 0", bus_if.tx_valid);
    end
  endtask

  task automatic test_cycle();
    logic [31:0] c0;
    logic [31:0] c1;
    @(negedge clk);
    bus_read(32'hFFFF_000C, c0);
    repeat (10) @(negedge clk);
    bus_read(32'hFFFF_000C, c1);
`ifdef DMEM_CYCLE_COUNTER_EN
    tests_run++;
    if (c1 - c0 !== 32'd10) begin
      tests_failed++;
      $display("[TB] FAIL cycle_delta got %0d want 10", c1 - c0);
    end
`else
    tests_run++;
    if (c0 !== 32'h0 || c1 !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL cycle_disabled got %h/%h want 0/0", c0, c1);
    end
`endif
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_ram();
    test_wrap();
    test_led();
    test_tx_overflow();
    test_back_to_back();
    test_cycle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
